// File: rtl/jpeg_pkg.sv
// Shared JPEG decode-path constants and helpers: default MCU size,
// ceiling log2 and the subsampling-ratio derivation.
package jpeg_pkg;

  localparam int MCU_WIDTH_DEFAULT  = 8;
  localparam int MCU_HEIGHT_DEFAULT = 8;

  // Ceiling log2, never below 1 so that counters for a range of one still have a bit.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int upsample_factor(input int in_sub, input int out_sub);
    return in_sub / out_sub;
  endfunction

endpackage

// File: rtl/upsampling_line_buffer.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Contents are not reset; only the control logic around it is.
module upsampling_line_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          i_sysclk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_sysclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/chroma_upsampling.sv
// Chroma upsampler: replicates each sample XF times and each row YF times,
// using a ping-pong line buffer, a 2-entry skid buffer and registered outputs.
module chroma_upsampling
  import jpeg_pkg::*;
#(
  parameter int XI_SUBSAMPLE    = 2,
  parameter int YI_SUBSAMPLE    = 2,
  parameter int XO_SUBSAMPLE    = 1,
  parameter int YO_SUBSAMPLE    = 1,
  parameter int MCU_WIDTH       = MCU_WIDTH_DEFAULT,
  parameter int MCU_HEIGHT      = MCU_HEIGHT_DEFAULT,
  parameter int COLOR_PRECISION = 8
) (
  input  logic                       i_sysclk,
  input  logic                       i_arst,
  input  logic                       i_we,
  input  logic [COLOR_PRECISION-1:0] i_color,
  output logic                       o_ready,
  output logic                       o_we,
  output logic [COLOR_PRECISION-1:0] o_color,
  output logic                       o_last,
  input  logic                       i_ready
);

  localparam int XF = upsample_factor(XI_SUBSAMPLE, XO_SUBSAMPLE);
  localparam int YF = upsample_factor(YI_SUBSAMPLE, YO_SUBSAMPLE);
  localparam int CW = log2(MCU_WIDTH);
  localparam int BW = log2(MCU_HEIGHT);
  localparam int XW = log2(XF);
  localparam int YW = log2(YF);
  localparam int AW = log2(2 * MCU_WIDTH);
  localparam int DW = COLOR_PRECISION;

  localparam logic [CW-1:0] COL_MAX    = CW'(MCU_WIDTH - 1);
  localparam logic [BW-1:0] ROW_MAX    = BW'(MCU_HEIGHT - 1);
  localparam logic [XW-1:0] X_MAX      = XW'(XF - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(YF - 1);
  localparam logic [AW-1:0] BANK1_BASE = AW'(MCU_WIDTH);

  logic [1:0]    r_full;
  logic          r_wbank;
  logic          r_rbank;
  logic [CW-1:0] r_wcol;
  logic [CW-1:0] r_rcol;
  logic [XW-1:0] r_xrep;
  logic [YW-1:0] r_yrep;
  logic [BW-1:0] r_brow;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [DW-1:0] r_skid_data [2];
  logic [1:0]    r_skid_last;
  logic [1:0]    r_skid_cnt;
  logic          r_o_we;
  logic [DW-1:0] r_o_color;
  logic          r_o_last;

  logic          w_wr_en;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;
  logic [2:0]    w_inflight;
  logic          w_rd_en;
  logic          w_x_end;
  logic          w_c_end;
  logic          w_y_end;
  logic          w_rd_final;
  logic          w_rd_tag_last;
  logic [DW-1:0] w_rd_data;
  logic          w_out_load;
  logic          w_src_valid;
  logic [DW-1:0] w_src_data;
  logic          w_src_last;
  logic          w_pop;
  logic          w_push;

  assign o_ready = !r_full[r_wbank];
  assign w_wr_en = i_we && !r_full[r_wbank];
  assign w_waddr = r_wbank ? (BANK1_BASE + AW'(r_wcol)) : AW'(r_wcol);
  assign w_raddr = r_rbank ? (BANK1_BASE + AW'(r_rcol)) : AW'(r_rcol);

  // Reads already in the RAM register count against skid space so it can never overflow.
  assign w_inflight    = {1'b0, r_skid_cnt} + {2'b00, r_rd_valid};
  assign w_rd_en       = r_full[r_rbank] && (w_inflight < 3'd2);
  assign w_x_end       = (r_xrep == X_MAX);
  assign w_c_end       = (r_rcol == COL_MAX);
  assign w_y_end       = (r_yrep == Y_MAX);
  assign w_rd_final    = w_rd_en && w_x_end && w_c_end && w_y_end;
  assign w_rd_tag_last = w_rd_final && (r_brow == ROW_MAX);

  upsampling_line_buffer #(
    .DEPTH (2 * MCU_WIDTH),
    .AW    (AW),
    .DW    (DW)
  ) u_line_buffer (
    .i_sysclk (i_sysclk),
    .i_we     (w_wr_en),
    .i_waddr  (w_waddr),
    .i_wdata  (i_color),
    .i_re     (w_rd_en),
    .i_raddr  (w_raddr),
    .o_rdata  (w_rd_data)
  );

  // The skid head takes priority; RAM data bypasses straight to the output when the skid is empty.
  always_comb begin
    w_out_load  = !r_o_we || i_ready;
    w_src_valid = 1'b0;
    w_src_data  = w_rd_data;
    w_src_last  = r_rd_last;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    if (r_skid_cnt != 2'd0) begin
      w_src_valid = 1'b1;
      w_src_data  = r_skid_data[0];
      w_src_last  = r_skid_last[0];
      w_pop       = w_out_load;
      w_push      = r_rd_valid;
    end else begin
      w_src_valid = r_rd_valid;
      w_push      = r_rd_valid && !w_out_load;
    end
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      r_full      <= '0;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_wcol      <= '0;
      r_rcol      <= '0;
      r_xrep      <= '0;
      r_yrep      <= '0;
      r_brow      <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_skid_data <= '{default: '0};
      r_skid_last <= '0;
      r_skid_cnt  <= '0;
      r_o_we      <= 1'b0;
      r_o_color   <= '0;
      r_o_last    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        if (r_wcol == COL_MAX) begin
          r_wcol          <= '0;
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= ~r_wbank;
        end else begin
          r_wcol <= r_wcol + 1'b1;
        end
      end

      // A bank being cleared here is never the bank being filled above.
      if (w_rd_en) begin
        if (w_x_end) begin
          r_xrep <= '0;
          if (w_c_end) begin
            r_rcol <= '0;
            if (w_y_end) begin
              r_yrep          <= '0;
              r_full[r_rbank] <= 1'b0;
              r_rbank         <= ~r_rbank;
              r_brow          <= (r_brow == ROW_MAX) ? '0 : r_brow + 1'b1;
            end else begin
              r_yrep <= r_yrep + 1'b1;
            end
          end else begin
            r_rcol <= r_rcol + 1'b1;
          end
        end else begin
          r_xrep <= r_xrep + 1'b1;
        end
      end

      r_rd_valid <= w_rd_en;
      r_rd_last  <= w_rd_tag_last;

      case ({w_pop, w_push})
        2'b10: begin
          r_skid_data[0] <= r_skid_data[1];
          r_skid_last[0] <= r_skid_last[1];
        end
        2'b01: begin
          if (r_skid_cnt == 2'd0) begin
            r_skid_data[0] <= w_rd_data;
            r_skid_last[0] <= r_rd_last;
          end else begin
            r_skid_data[1] <= w_rd_data;
            r_skid_last[1] <= r_rd_last;
          end
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid_data[0] <= w_rd_data;
            r_skid_last[0] <= r_rd_last;
          end else begin
            r_skid_data[0] <= r_skid_data[1];
            r_skid_last[0] <= r_skid_last[1];
            r_skid_data[1] <= w_rd_data;
            r_skid_last[1] <= r_rd_last;
          end
        end
        default: ;
      endcase
      r_skid_cnt <= r_skid_cnt + {1'b0, w_push} - {1'b0, w_pop};

      if (w_out_load) begin
        r_o_we   <= w_src_valid;
        r_o_last <= w_src_valid && w_src_last;
        if (w_src_valid) r_o_color <= w_src_data;
      end
    end
  end

  assign o_we    = r_o_we;
  assign o_color = r_o_color;
  assign o_last  = r_o_last;

endmodule

// File: doc/chroma_upsampling.md
# chroma_upsampling

Reconstructs full-resolution chroma from a subsampled chroma block stream on the JPEG decode path, ahead of colour conversion. Each input sample is replicated horizontally XF = XI_SUBSAMPLE/XO_SUBSAMPLE times, and each input row is replayed vertically YF = YI_SUBSAMPLE/YO_SUBSAMPLE times. A ping-pong line buffer decouples the input rate from the higher output rate, and both sides use valid/ready handshakes.

## Interface
- XI_SUBSAMPLE, default 2: horizontal subsampling factor of the input stream.
- YI_SUBSAMPLE, default 2: vertical subsampling factor of the input stream.
- XO_SUBSAMPLE, default 1: horizontal subsampling factor of the output stream. XI_SUBSAMPLE must be an integer multiple of it.
- YO_SUBSAMPLE, default 1: vertical subsampling factor of the output stream. YI_SUBSAMPLE must be an integer multiple of it.
- MCU_WIDTH, default 8: input block width in samples (≥2).
- MCU_HEIGHT, default 8: input block height in samples (≥1).
- COLOR_PRECISION, default 8: sample width in bits.
- i_sysclk  in  1  clock.
- i_arst  in  1  reset; asynchronous, active-high.
- i_we  in  1  input sample valid.
- i_color  in  COLOR_PRECISION  input sample, raster order within the block.
- o_ready  out  1  input ready. A sample is accepted on an edge where i_we && o_ready.
- o_we  out  1  output sample valid.
- o_color  out  COLOR_PRECISION  output sample, raster order within the expanded block of (MCU_WIDTH·XF) × (MCU_HEIGHT·YF) samples.
- o_last  out  1  asserted with the final sample of each expanded block.
- i_ready  in  1  downstream ready. An output transfer occurs when o_we && i_ready.

## Operation
- Line buffer: 2 banks × MCU_WIDTH entries. Each bank has a full flag. The write side tracks wbank; the read side tracks rbank.
- Write side:
  - o_ready = !full[wbank], derived combinationally from registered state.
  - Each accepted sample is written to (wbank, wcol), then wcol increments.
  - At wcol = MCU_WIDTH−1: wcol wraps to 0, full[wbank] is set, and wbank toggles.
- Read side runs while full[rbank] is set.
  - Nested counters, innermost first: xrep 0..XF−1, rcol 0..MCU_WIDTH−1, yrep 0..YF−1.
  - Each issued read address is rcol.
  - After the read for (xrep=XF−1, rcol=W−1, yrep=YF−1) is issued: full[rbank] clears, rbank toggles, and brow increments, wrapping at MCU_HEIGHT−1.
- o_last is tagged on the read where brow = MCU_HEIGHT−1 and all three inner counters are at their maximum.
- Output pipeline: registered RAM read, then a 2-entry skid buffer, then the o_we/o_color/o_last registers.
  - A read is issued only if the skid buffer has space, counting in-flight reads.
- Back-pressure: while o_we && !i_ready, o_color and o_last hold stable and o_we stays asserted. No sample is dropped or duplicated beyond the defined replication.
- A set of full[] on the write side and a clear on the read side in the same cycle always target different banks, so no arbitration is needed.
- XF = YF = 1: the block acts as a buffered pass-through with unchanged ordering.
- Reset, including mid-block: all counters, bank pointers and full flags clear, and the skid buffer empties. Partial rows are discarded.

## Timing
- Reset values: o_we=0, o_color=0, o_last=0. o_ready=1 from the first edge after i_arst deasserts.
- Latency: the row's last sample is accepted at edge T; full is set at T+1; the first read is issued in cycle T+1; o_we=1 after edge T+2.
- Throughput: 1 output sample per cycle sustained while i_ready=1 and the input keeps one bank ahead.
- Input: an input row takes MCU_WIDTH cycles; its replay takes MCU_WIDTH·XF·YF cycles. The input therefore stalls via o_ready=0 once both banks are full.
- i_ready deasserted for N cycles: the output pauses for exactly N cycles, with no bubble after i_ready returns.

## Structure
- Shared package (jpeg_pkg), existing shared constants: the log2 function; the XF/YF derivation; the default MCU dimensions.
- Sub-module upsampling_line_buffer: simple dual-port RAM with 2·MCU_WIDTH entries, one write port, one read port, registered read, no reset on contents.
- The top level holds the write/read counters, full flags, skid buffer and output registers.

## Test plan
- 2×2 upsampling, 8×8 block, input row 0 = 0..7, i_ready=1 → output rows 0 and 1 are both 0,0,1,1,…,7,7. The first o_we occurs 2 cycles after sample 7 is accepted.
- Full block, input values 0..63 streamed continuously → 256 outputs with no gaps after the first. o_last=1 only on output #255, value 63.
- i_ready=0 for 5 cycles mid-row at output value 3 → o_color holds 3 and o_we stays 1; the sequence resumes with no loss or duplication. o_ready drops to 0 once both banks are full.
- XF=YF=1, 8×8 → output equals input order. Latency is 2 cycles after each row completes.
- i_arst asserted after 5 samples of a row, then a fresh block → o_we=0 and o_ready=1 after reset. The output contains only the new block's data, correctly replicated.
- XI_SUBSAMPLE=2, YI_SUBSAMPLE=1 (4:2:2) → each row is emitted once, with every sample doubled horizontally: 128 outputs per block.
